// File: rtl/mdu_pkg.sv
// Shared encodings, FSM state type and constants for the RV32M multiply/divide unit.
`timescale 1ns/1ps
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  localparam int ITER_CNT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is treated as signed by MUL, MULH, DIV and REM.
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Shared iterative datapath: radix-2 shift-add multiply and restoring divide on
// unsigned magnitudes, one step per enabled cycle, ITER_CNT steps per operation.
`timescale 1ns/1ps
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  // {hi_q, lo_q}: product (multiply) or {remainder, quotient/dividend} (divide)
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;
  logic            div_q;
  logic [5:0]      cnt_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;
  logic [XLEN-1:0] hi_d;
  logic [XLEN-1:0] lo_d;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (div_q) begin
      // A clear borrow bit means the trial subtraction fits: keep it, shift in a 1.
      if (!rem_diff[XLEN]) begin
        hi_d = rem_diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign done = (cnt_q == 6'(ITER_CNT));
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a_mag;
      b_q   <= b_mag;
      div_q <= is_div;
      cnt_q <= '0;
    end else if (step && !done) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/mdu.sv
// RV32M multiply/divide unit: IDLE/CALC/DONE handshake FSM, special-case bypass and
// sign fix-up around mdu_iter. Define MDU_FAST_MUL_EN for single-cycle multiplies.
`timescale 1ns/1ps
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] C
);

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      op_p0;
  logic [XLEN-1:0] a_p0;
  logic [XLEN-1:0] b_p0;
  logic [XLEN-1:0] c_q;
  logic [XLEN-1:0] c_d;
  logic            c_load;
  logic            accept;

  logic            sa_in;
  logic            sb_in;
  logic [XLEN-1:0] a_mag_in;
  logic [XLEN-1:0] b_mag_in;

  logic            iter_done;
  logic [XLEN-1:0] iter_hi;
  logic [XLEN-1:0] iter_lo;

  logic              neg_a;
  logic              neg_b;
  logic [2*XLEN-1:0] prod_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   iter_res;

  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;
  logic            bypass;
  logic [XLEN-1:0] bypass_res;

  assign accept = in_valid && (state_q == S_IDLE) && !flush;

  // Magnitudes are formed from the live operands so the iterator loads on the accept edge.
  assign sa_in    = op_signed_a(op) && A[XLEN-1];
  assign sb_in    = op_signed_b(op) && B[XLEN-1];
  assign a_mag_in = sa_in ? -A : A;
  assign b_mag_in = sb_in ? -B : B;

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rstn   (rstn),
    .load   (accept),
    .step   (state_q == S_CALC),
    .is_div (op[2]),
    .a_mag  (a_mag_in),
    .b_mag  (b_mag_in),
    .done   (iter_done),
    .hi     (iter_hi),
    .lo     (iter_lo)
  );

  // Sign fix-up of the iterative result from the latched request
  assign neg_a = op_signed_a(op_p0) && a_p0[XLEN-1];
  assign neg_b = op_signed_b(op_p0) && b_p0[XLEN-1];

  always_comb begin
    prod_mag = {iter_hi, iter_lo};
    prod     = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
    quo      = (neg_a ^ neg_b) ? -iter_lo : iter_lo;
    rem      = neg_a ? -iter_hi : iter_hi;
    if (op_p0[2]) begin
      iter_res = op_p0[1] ? rem : quo;
    end else if (op_p0 == MDU_MUL) begin
      iter_res = prod[XLEN-1:0];
    end else begin
      iter_res = prod[2*XLEN-1:XLEN];
    end
  end

  // Divide by zero and the signed most-negative / -1 overflow skip the iterations.
  assign div_zero = op_p0[2] && (b_p0 == '0);
  assign div_ovf  = ((op_p0 == MDU_DIV) || (op_p0 == MDU_REM)) &&
                    (a_p0 == {1'b1, {(XLEN-1){1'b0}}}) && (b_p0 == '1);

  always_comb begin
    if (div_zero) begin
      special_res = op_p0[1] ? a_p0 : '1;
    end else begin
      special_res = op_p0[1] ? '0 : a_p0;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a;
  logic signed [2*XLEN-1:0] fast_b;
  logic signed [2*XLEN-1:0] fast_p;
  logic                     fast_mul;
  logic [XLEN-1:0]          fast_res;

  // 33-bit signed operands (extension bit set only for signed, negative inputs)
  assign fast_a   = $signed({{XLEN{neg_a}}, a_p0});
  assign fast_b   = $signed({{XLEN{neg_b}}, b_p0});
  assign fast_p   = fast_a * fast_b;
  assign fast_mul = !op_p0[2];
  assign fast_res = (op_p0 == MDU_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];

  assign bypass     = div_zero || div_ovf || fast_mul;
  assign bypass_res = fast_mul ? fast_res : special_res;
`else
  assign bypass     = div_zero || div_ovf;
  assign bypass_res = special_res;
`endif

  always_comb begin
    state_d   = state_q;
    c_load    = 1'b0;
    c_d       = c_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_CALC;
      end
      S_CALC: begin
        if (bypass) begin
          state_d = S_DONE;
          c_load  = 1'b1;
          c_d     = bypass_res;
        end else if (iter_done) begin
          state_d = S_DONE;
          c_load  = 1'b1;
          c_d     = iter_res;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      c_load  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      op_p0   <= '0;
      a_p0    <= '0;
      b_p0    <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_p0 <= op;
        a_p0  <= A;
        b_p0  <= B;
      end
      if (c_load) c_q <= c_d;
    end
  end

  assign C = c_q;

endmodule
